// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O bus arbiter: FSM states, master indices
// and the I/O register map addresses.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    localparam logic [7:0] ADDR_LED      = 8'h00;
    localparam logic [7:0] ADDR_BTN      = 8'h04;
    localparam logic [7:0] ADDR_SEG_RDY  = 8'h08;
    localparam logic [7:0] ADDR_SEG      = 8'h0C;
    localparam logic [7:0] ADDR_SW_AVAIL = 8'h10;
    localparam logic [7:0] ADDR_SW       = 8'h14;
    localparam logic [7:0] ADDR_CNT      = 8'h18;

    // Registers are word-aligned; any low address bit set is a rejected access.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Request/ack handshake between one bus master and the arbiter.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: one-hot grant, tie goes to the master that was
// not granted last, or always to master 0 in fixed-priority mode.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic [1:0] grant
);
    always_comb begin
        if (req == 2'b11) begin
            grant = (mode || last) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the I/O register bus between the CPU and the debug port; every
// transaction produces exactly one bus strobe (or none if misaligned) and one ack.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    io_bus_arbiter_if.slave      m0,
    io_bus_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0]    io_addr,
    output logic [DATA_W-1:0]    io_dout,
    output logic                 io_we,
    output logic                 io_rd,
    input  logic [DATA_W-1:0]    io_din,
    output logic                 busy,
    output logic                 owner
);
    localparam logic FIXED_PRIO = (PRIORITY_MODE != 0);

    state_t            state;
    logic              lat_we;
    logic              lat_err;
    logic [1:0]        grant;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    rr_arbiter2 u_arb (
        .req   ({m1.req, m0.req}),
        .last  (owner),
        .mode  (FIXED_PRIO),
        .grant (grant)
    );

    assign sel       = grant[1];
    assign sel_we    = sel ? m1.we    : m0.we;
    assign sel_addr  = sel ? m1.addr  : m0.addr;
    assign sel_wdata = sel ? m1.wdata : m0.wdata;
    assign sel_bad   = misaligned(sel_addr[1:0]);

    // NOTE: all state here is registered with non-blocking assignments, and the async
    // reset also clears both rdata holding registers so no stale read data survives it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            io_addr  <= '0;
            io_dout  <= '0;
            io_we    <= 1'b0;
            io_rd    <= 1'b0;
            busy     <= 1'b0;
            owner    <= M_DBG;
            lat_we   <= 1'b0;
            lat_err  <= 1'b0;
            m0.ack   <= 1'b0;
            m0.err   <= 1'b0;
            m0.rdata <= '0;
            m1.ack   <= 1'b0;
            m1.err   <= 1'b0;
            m1.rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner   <= sel;
                        lat_we  <= sel_we;
                        lat_err <= sel_bad;
                        io_addr <= sel_addr;
                        io_dout <= sel_wdata;
                        // Strobes are launched here so they are high for the whole ISSUE cycle.
                        io_we   <= sel_we & ~sel_bad;
                        io_rd   <= ~sel_we & ~sel_bad;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    io_we <= 1'b0;
                    io_rd <= 1'b0;
                    if (owner == M_CPU) begin
                        m0.ack <= 1'b1;
                        m0.err <= lat_err;
                        if (lat_err)      m0.rdata <= '0;
                        else if (!lat_we) m0.rdata <= io_din;
                    end else begin
                        m1.ack <= 1'b1;
                        m1.err <= lat_err;
                        if (lat_err)      m1.rdata <= '0;
                        else if (!lat_we) m1.rdata <= io_din;
                    end
                    state <= RESP;
                end
                RESP: begin
                    m0.ack <= 1'b0;
                    m0.err <= 1'b0;
                    m1.ack <= 1'b0;
                    m1.err <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: a round-robin and a fixed-priority instance run the same
// master scripts against a transaction-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Bench-side views indexed [instance][master]; instance 0 round-robin, 1 fixed priority.
    logic        req_s   [2][2];
    logic        we_s    [2][2];
    logic [7:0]  addr_s  [2][2];
    logic [31:0] wdata_s [2][2];
    logic        ack_s   [2][2];
    logic        err_s   [2][2];
    logic [31:0] rdata_s [2][2];
    logic [7:0]  io_addr_s [2];
    logic [31:0] io_dout_s [2];
    logic [31:0] io_din_s  [2];
    logic        io_we_s   [2];
    logic        io_rd_s   [2];
    logic        busy_s    [2];
    logic        owner_s   [2];

    function automatic logic [31:0] regmap(input logic [7:0] a);
        return (a == ADDR_SW) ? 32'hDEAD_BEEF : {24'h5A5A5A, a};
    endfunction

    io_bus_arbiter_if ifc_r0 ();
    io_bus_arbiter_if ifc_r1 ();
    io_bus_arbiter_if ifc_p0 ();
    io_bus_arbiter_if ifc_p1 ();

    assign {ifc_r0.req, ifc_r0.we, ifc_r0.addr, ifc_r0.wdata} = {req_s[0][0], we_s[0][0], addr_s[0][0], wdata_s[0][0]};
    assign {ifc_r1.req, ifc_r1.we, ifc_r1.addr, ifc_r1.wdata} = {req_s[0][1], we_s[0][1], addr_s[0][1], wdata_s[0][1]};
    assign {ifc_p0.req, ifc_p0.we, ifc_p0.addr, ifc_p0.wdata} = {req_s[1][0], we_s[1][0], addr_s[1][0], wdata_s[1][0]};
    assign {ifc_p1.req, ifc_p1.we, ifc_p1.addr, ifc_p1.wdata} = {req_s[1][1], we_s[1][1], addr_s[1][1], wdata_s[1][1]};
    assign {ack_s[0][0], err_s[0][0], rdata_s[0][0]} = {ifc_r0.ack, ifc_r0.err, ifc_r0.rdata};
    assign {ack_s[0][1], err_s[0][1], rdata_s[0][1]} = {ifc_r1.ack, ifc_r1.err, ifc_r1.rdata};
    assign {ack_s[1][0], err_s[1][0], rdata_s[1][0]} = {ifc_p0.ack, ifc_p0.err, ifc_p0.rdata};
    assign {ack_s[1][1], err_s[1][1], rdata_s[1][1]} = {ifc_p1.ack, ifc_p1.err, ifc_p1.rdata};
    assign io_din_s[0] = regmap(io_addr_s[0]);
    assign io_din_s[1] = regmap(io_addr_s[1]);

    io_bus_arbiter #(.PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .rstn(rstn), .m0(ifc_r0), .m1(ifc_r1),
        .io_addr(io_addr_s[0]), .io_dout(io_dout_s[0]), .io_we(io_we_s[0]), .io_rd(io_rd_s[0]),
        .io_din(io_din_s[0]), .busy(busy_s[0]), .owner(owner_s[0])
    );

    io_bus_arbiter #(.PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rstn(rstn), .m0(ifc_p0), .m1(ifc_p1),
        .io_addr(io_addr_s[1]), .io_dout(io_dout_s[1]), .io_we(io_we_s[1]), .io_rd(io_rd_s[1]),
        .io_din(io_din_s[1]), .busy(busy_s[1]), .owner(owner_s[1])
    );

    // Master scripts (shared by both instances) and per-instance progress pointers.
    txn_t scr [2][8];
    int   n_scr [2] = '{0, 0};
    int   ptr [2][2];
    int   epoch = 0;

    // Transaction-level model: a granted transaction strobes next cycle, acks the one after.
    int          slot [2];
    logic        last [2];
    logic        cur_m [2];
    txn_t        cur [2];
    logic        cur_bad [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_dout [2];
    logic [31:0] m_rdata [2][2];

    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                slot[i] = 0;
                last[i] = 1'b1;
                cur_m[i] = 1'b0;
                cur[i] = '0;
                cur_bad[i] = 1'b0;
                m_addr[i] = '0;
                m_dout[i] = '0;
                m_rdata[i][0] = '0;
                m_rdata[i][1] = '0;
            end else if (slot[i] == 0) begin
                if (req_s[i][0] || req_s[i][1]) begin
                    logic w;
                    if (req_s[i][0] && req_s[i][1]) w = (i == 1) ? 1'b0 : !last[i];
                    else                            w = req_s[i][1];
                    cur_m[i] = w;
                    cur[i] = {we_s[i][w], addr_s[i][w], wdata_s[i][w]};
                    cur_bad[i] = (addr_s[i][w] % 4) != 0;
                    m_addr[i] = addr_s[i][w];
                    m_dout[i] = wdata_s[i][w];
                    last[i] = w;
                    slot[i] = 1;
                end
            end else if (slot[i] == 1) begin
                if (cur_bad[i])      m_rdata[i][cur_m[i]] = '0;
                else if (!cur[i].we) m_rdata[i][cur_m[i]] = regmap(cur[i].addr);
                slot[i] = 2;
            end else begin
                slot[i] = 0;
            end
        end
    end

    // Event log for literal checks.
    int          cyc = 0;
    int          seen_epoch = 0;
    int          n_s [2];
    int          s_cyc [2][16];
    logic        s_we [2][16];
    logic [7:0]  s_addr [2][16];
    logic [31:0] s_dout [2][16];
    int          n_a [2];
    int          a_cyc [2][16];
    logic        a_m [2][16];
    logic        a_err [2][16];

    // Per-cycle compare against the model, event logging, then master behaviour.
    always @(negedge clk) begin
        cyc++;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            n_s[0] = 0; n_s[1] = 0; n_a[0] = 0; n_a[1] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("io_we[%0d]", i), io_we_s[i], (slot[i] == 1) && cur[i].we && !cur_bad[i]);
            check($sformatf("io_rd[%0d]", i), io_rd_s[i], (slot[i] == 1) && !cur[i].we && !cur_bad[i]);
            check($sformatf("io_addr[%0d]", i), io_addr_s[i], m_addr[i]);
            check($sformatf("io_dout[%0d]", i), io_dout_s[i], m_dout[i]);
            check($sformatf("busy[%0d]", i), busy_s[i], slot[i] != 0);
            check($sformatf("owner[%0d]", i), owner_s[i], last[i]);
            for (int j = 0; j < 2; j++) begin
                check($sformatf("ack[%0d][%0d]", i, j), ack_s[i][j], (slot[i] == 2) && (cur_m[i] == j));
                check($sformatf("err[%0d][%0d]", i, j), err_s[i][j], (slot[i] == 2) && (cur_m[i] == j) && cur_bad[i]);
                check($sformatf("rdata[%0d][%0d]", i, j), rdata_s[i][j], m_rdata[i][j]);
            end
            if ((io_we_s[i] || io_rd_s[i]) && n_s[i] < 16) begin
                s_cyc[i][n_s[i]] = cyc;
                s_we[i][n_s[i]] = io_we_s[i];
                s_addr[i][n_s[i]] = io_addr_s[i];
                s_dout[i][n_s[i]] = io_dout_s[i];
                n_s[i]++;
            end
            for (int j = 0; j < 2; j++) begin
                if (ack_s[i][j] && n_a[i] < 16) begin
                    a_cyc[i][n_a[i]] = cyc;
                    a_m[i][n_a[i]] = (j == 1);
                    a_err[i][n_a[i]] = err_s[i][j];
                    n_a[i]++;
                end
                if (!rstn)               ptr[i][j] = 0;
                else if (ack_s[i][j])    ptr[i][j]++;
                if (ptr[i][j] < n_scr[j]) begin
                    req_s[i][j] = 1'b1;
                    {we_s[i][j], addr_s[i][j], wdata_s[i][j]} = scr[j][ptr[i][j]];
                end else begin
                    req_s[i][j] = 1'b0;
                    {we_s[i][j], addr_s[i][j], wdata_s[i][j]} = '0;
                end
            end
        end
    end

    task automatic begin_test();
        rstn = 1'b0;
        n_scr[0] = 0;
        n_scr[1] = 0;
        @(negedge clk);
        epoch++;
        @(negedge clk);
    endtask

    task automatic add(input int j, input logic we, input logic [7:0] a, input logic [31:0] d);
        scr[j][n_scr[j]] = {we, a, d};
        n_scr[j]++;
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            #1;
            done = (ptr[0][0] == n_scr[0]) && (ptr[0][1] == n_scr[1]) &&
                   (ptr[1][0] == n_scr[0]) && (ptr[1][1] == n_scr[1]) &&
                   (slot[0] == 0) && (slot[1] == 0);
        end
        check("scripts_done", done, 1'b1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic go(output int c0);
        @(negedge clk);
        #2 rstn = 1'b1;
        c0 = cyc;
        wait_done();
    endtask

    initial begin
        int c0;
        logic [7:0] ord_rr;
        logic [7:0] ord_fp;
        ord_rr = 8'hAA;
        ord_fp = 8'hF0;

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", busy_s[i], 1'b0);
            check("rst_owner", owner_s[i], 1'b1);
            check("rst_strobes", {io_we_s[i], io_rd_s[i]}, 2'b00);
            check("rst_io_addr", io_addr_s[i], 8'h00);
            check("rst_rdata", {rdata_s[i][0], rdata_s[i][1]}, 64'h0);
        end

        // m0 writes LED
        begin_test();
        add(0, 1'b1, ADDR_LED, 32'h0000_00A5);
        go(c0);
        for (int i = 0; i < 2; i++) begin
            check("t1_strobes", n_s[i], 1);
            check("t1_strobe_cyc", s_cyc[i][0], c0 + 1);
            check("t1_we", s_we[i][0], 1'b1);
            check("t1_addr", s_addr[i][0], 8'h00);
            check("t1_dout", s_dout[i][0], 32'hA5);
            check("t1_acks", n_a[i], 1);
            check("t1_ack_cyc", a_cyc[i][0], c0 + 2);
            check("t1_ack_m", a_m[i][0], 1'b0);
            check("t1_ack_err", a_err[i][0], 1'b0);
        end

        // m0 reads BTN, m1 reads SW
        begin_test();
        add(0, 1'b0, ADDR_BTN, 32'h0);
        add(1, 1'b0, ADDR_SW, 32'h0);
        go(c0);
        for (int i = 0; i < 2; i++) begin
            check("t2_strobes", n_s[i], 2);
            check("t2_rd_addr", {s_we[i][1], s_addr[i][1]}, {1'b0, 8'h14});
            check("t2_ack_m", {a_m[i][0], a_m[i][1]}, 2'b01);
            check("t2_m1_rdata", rdata_s[i][1], 32'hDEAD_BEEF);
            check("t2_m0_rdata", rdata_s[i][0], 32'h5A5A_5A04);
        end

        // both masters stream four transactions each
        begin_test();
        for (int k = 0; k < 4; k++) begin
            add(0, 1'b1, 8'(4 * k), 32'(k + 1));
            add(1, 1'b0, 8'(ADDR_SW_AVAIL + 8'(4 * k)), 32'h0);
        end
        go(c0);
        for (int i = 0; i < 2; i++) begin
            check("t3_acks", n_a[i], 8);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("t3_order[%0d][%0d]", i, k), a_m[i][k], (i == 0) ? ord_rr[k] : ord_fp[k]);
                check($sformatf("t3_ack_cyc[%0d][%0d]", i, k), a_cyc[i][k], c0 + 2 + 3 * k);
            end
            check("t3_m1_rdata", rdata_s[i][1], 32'h5A5A_5A1C);
        end

        // misaligned read after a good one
        begin_test();
        add(0, 1'b0, ADDR_BTN, 32'h0);
        add(0, 1'b0, 8'h15, 32'h0);
        go(c0);
        for (int i = 0; i < 2; i++) begin
            check("t4_strobes", n_s[i], 1);
            check("t4_acks", n_a[i], 2);
            check("t4_err", {a_err[i][0], a_err[i][1]}, 2'b01);
            check("t4_rdata", rdata_s[i][0], 32'h0);
        end

        // reset during the ISSUE cycle of a write to SEG
        begin_test();
        add(0, 1'b1, ADDR_SEG, 32'h0000_1234);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #2;
        check("t5_we_before", {io_we_s[0], io_we_s[1]}, 2'b11);
        rstn = 1'b0;
        #1;
        check("t5_we_async", {io_we_s[0], io_we_s[1]}, 2'b00);
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("t5_no_ack", n_a[i], 0);
            check("t5_busy", busy_s[i], 1'b0);
            check("t5_owner", owner_s[i], 1'b1);
        end
        epoch++;
        @(negedge clk);
        go(c0);
        for (int i = 0; i < 2; i++) begin
            check("t5_redo_strobes", n_s[i], 1);
            check("t5_redo_addr", s_addr[i][0], 8'h0C);
            check("t5_redo_ack_cyc", a_cyc[i][0], c0 + 2);
        end

        // back-to-back m0 transactions: new request in the cycle after ack
        begin_test();
        add(0, 1'b1, ADDR_SEG_RDY, 32'h7);
        add(0, 1'b0, ADDR_CNT, 32'h0);
        go(c0);
        for (int i = 0; i < 2; i++) begin
            check("t6_strobes", n_s[i], 2);
            check("t6_gap", s_cyc[i][1] - s_cyc[i][0], 3);
            check("t6_addr2", {s_we[i][1], s_addr[i][1]}, {1'b0, 8'h18});
            check("t6_rdata", rdata_s[i][0], 32'h5A5A_5A18);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
